spi_bus_arbiter: RTL and testbench

- Shares the single board SPI bus (SCK via the user master-clock primitive, MOSI, MISO) between two requesters: requester 0 is the SD-card loader, requester 1 is the config-flash/debug bridge.
- Arbitrates whole transactions round-robin and drives the per-device chip selects with programmable setup/hold timing.
- Contains a mode-0 byte shifter with per-requester valid/ready byte handshakes.
- Sits between GameBrian's storage clients and the top-level SPI pins.

---
 rtl/spi_bus_arbiter_if.sv | 22 ++
 rtl/spi_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Requester-side bus of the SPI arbiter: transaction requests, grants and
// per-requester byte handshakes.
interface spi_bus_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  tx_valid;
  logic [15:0] tx_data;
  logic [1:0]  tx_ready;
  logic [1:0]  rx_valid;
  logic [7:0]  rx_data;
  logic        busy;

  modport master (
    output req, tx_valid, tx_data,
    input  gnt, tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  req, tx_valid, tx_data,
    output gnt, tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI bus arbiter: round-robin whole-transaction grants,
// chip-select setup/hold timing and a mode-0 MSB-first byte shifter.
module spi_bus_arbiter #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_bus_arbiter_if.slave bus,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic [1:0]       spi_cs_n
);

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, SHIFT, HOLD, GAP} state_t;

  state_t      state, state_nx;
  logic        last, last_nx;
  logic [15:0] cnt, cnt_nx;
  logic [3:0]  half, half_nx;
  logic [7:0]  tx_sh, tx_sh_nx;
  logic [7:0]  rx_sh, rx_sh_nx;
  logic [7:0]  rx_q, rx_q_nx;
  logic        mosi_q, mosi_nx;
  logic [1:0]  rxv_q, rxv_nx;

  logic [1:0]  sel_oh;
  logic        active;
  logic        req_sel;
  logic        valid_sel;
  logic [7:0]  data_sel;

  // The last-grant pointer doubles as the current owner once a grant is made.
  assign sel_oh    = last ? 2'b10 : 2'b01;
  assign req_sel   = bus.req[last];
  assign valid_sel = bus.tx_valid[last];
  assign data_sel  = last ? bus.tx_data[15:8] : bus.tx_data[7:0];
  assign active    = (state == SETUP) || (state == WAIT) ||
                     (state == SHIFT) || (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      half   <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      rx_q   <= '0;
      mosi_q <= 1'b0;
      rxv_q  <= '0;
    end else begin
      state  <= state_nx;
      last   <= last_nx;
      cnt    <= cnt_nx;
      half   <= half_nx;
      tx_sh  <= tx_sh_nx;
      rx_sh  <= rx_sh_nx;
      rx_q   <= rx_q_nx;
      mosi_q <= mosi_nx;
      rxv_q  <= rxv_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    cnt_nx   = cnt;
    half_nx  = half;
    tx_sh_nx = tx_sh;
    rx_sh_nx = rx_sh;
    rx_q_nx  = rx_q;
    mosi_nx  = mosi_q;
    rxv_nx   = '0;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.req != 2'b00) begin
          state_nx = SETUP;
          last_nx  = (bus.req == 2'b11) ? ~last : bus.req[1];
        end
      end

      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nx   = '0;
          state_nx = WAIT;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      WAIT: begin
        // A handshake takes priority over a simultaneous request drop.
        if (valid_sel) begin
          state_nx = SHIFT;
          tx_sh_nx = data_sel;
          mosi_nx  = data_sel[7];
          cnt_nx   = '0;
          half_nx  = '0;
        end else if (!req_sel) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end
      end

      SHIFT: begin
        // half counts SCK half-periods: even = low phase, odd = high phase.
        if (cnt == DIV_LAST) begin
          cnt_nx  = '0;
          half_nx = half + 4'd1;
          if (!half[0]) begin
            rx_sh_nx = {rx_sh[6:0], spi_miso};
          end else if (half == 4'd15) begin
            state_nx = WAIT;
            rx_q_nx  = rx_sh;
            rxv_nx   = sel_oh;
          end else begin
            tx_sh_nx = {tx_sh[6:0], 1'b0};
            mosi_nx  = tx_sh[6];
          end
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx   = '0;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      GAP: state_nx = IDLE;

      default: state_nx = IDLE;
    endcase
  end

  assign bus.gnt      = active ? sel_oh : 2'b00;
  assign bus.tx_ready = (state == WAIT) ? sel_oh : 2'b00;
  assign bus.rx_valid = rxv_q;
  assign bus.rx_data  = rx_q;
  assign bus.busy     = (state != IDLE);
  assign spi_cs_n     = ~bus.gnt;
  assign spi_sck      = (state == SHIFT) && half[0];
  assign spi_mosi     = mosi_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: loopback and scripted-slave MISO,
// round-robin grant model, chip-select timing and reset behaviour.
module tb_spi_bus_arbiter;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned CS_SETUP  = 2;
  localparam int unsigned CS_HOLD   = 2;
  localparam int          BYTE_LAT  = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck, spi_mosi, spi_miso;
  logic [1:0] spi_cs_n;

  int checks = 0;
  int passes = 0;

  spi_bus_arbiter_if bus ();

  spi_bus_arbiter #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .spi_sck (spi_sck),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  // Slave side: loopback, or a scripted byte shifted out MSB first on SCK falls.
  bit         miso_mode = 1'b0;
  logic [7:0] slave_byte = '0;
  int         fall_cnt = 0;
  int         fall_base = 0;
  logic       slave_bit;

  always @(negedge spi_sck) fall_cnt++;

  always @* begin
    int k;
    k = fall_cnt - fall_base;
    slave_bit = (k >= 0 && k < 8) ? slave_byte[7 - k] : 1'b0;
  end

  assign spi_miso = miso_mode ? slave_bit : spi_mosi;

  // MOSI capture at SCK rises, assembled into whole bytes.
  logic [7:0] mosi_q[$];
  int         mq_rd = 0;
  int         rise_cnt = 0;
  int         cap_bits = 0;
  logic [7:0] cap_sh = '0;

  always @(posedge spi_sck or negedge rst_n) begin
    if (!rst_n) begin
      cap_bits = 0;
    end else begin
      rise_cnt++;
      cap_sh = {cap_sh[6:0], spi_mosi};
      cap_bits++;
      if (cap_bits == 8) begin
        mosi_q.push_back(cap_sh);
        cap_bits = 0;
      end
    end
  end

  // Chip-select invariants and change counter.
  int         inv_bad = 0;
  int         cs_changes = 0;
  logic [1:0] cs_prev = 2'b11;

  always @(negedge clk) begin
    if (spi_cs_n == 2'b00) inv_bad++;
    if (!spi_cs_n[0] && !bus.gnt[0]) inv_bad++;
    if (!spi_cs_n[1] && !bus.gnt[1]) inv_bad++;
    if (spi_cs_n !== cs_prev) cs_changes++;
    cs_prev = spi_cs_n;
  end

  // Round-robin reference: pointer names the requester granted last.
  logic m_last = 1'b1;

  function automatic logic [1:0] exp_grant(input logic [1:0] r);
    if (r == 2'b11) return m_last ? 2'b01 : 2'b10;
    return r[1] ? 2'b10 : 2'b01;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    int n = 0;
    while (bus.gnt == 2'b00 && n < 100) begin
      tick;
      n++;
    end
    g = bus.gnt;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (bus.busy && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL idle_timeout: busy=%b required 0", bus.busy);
    else passes++;
  endtask

  task automatic get_mosi(output logic [7:0] v);
    if (mq_rd < mosi_q.size()) begin
      v = mosi_q[mq_rd];
      mq_rd++;
    end else begin
      v = 'x;
    end
  endtask

  // Sends one byte from requester r; optionally drops req[r] drop_at cycles
  // after the handshake. lat = cycles from handshake edge to rx_valid.
  task automatic send_byte(input int r, input logic [7:0] b, input int drop_at,
                           output logic [7:0] got, output int lat);
    int n = 0;
    if (r == 0) bus.tx_data[7:0] = b;
    else        bus.tx_data[15:8] = b;
    bus.tx_valid[r] = 1'b1;
    while (!bus.tx_ready[r] && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (bus.tx_ready[r] !== 1'b1) $display("FAIL ready_timeout: tx_ready[%0d]=%b required 1", r, bus.tx_ready[r]);
    else passes++;
    fall_base = fall_cnt;
    tick;
    bus.tx_valid[r] = 1'b0;
    lat = 0;
    while (!bus.rx_valid[r] && lat < 400) begin
      tick;
      lat++;
      if (lat == drop_at) bus.req[r] = 1'b0;
    end
    got = bus.rx_data;
  endtask

  // Drops all requests at the rx_valid cycle and checks CS release timing.
  task automatic check_release(input string tag);
    int n = 0;
    bus.req = 2'b00;
    while (spi_cs_n != 2'b11 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (n !== CS_HOLD + 1) $display("FAIL %s_cs_release: cycles=%0d required %0d", tag, n, CS_HOLD + 1);
    else passes++;
    checks++;
    if (bus.busy !== 1'b1 || bus.gnt !== 2'b00) $display("FAIL %s_gap: busy=%b gnt=%b required 1/00", tag, bus.busy, bus.gnt);
    else passes++;
    tick;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL %s_idle: busy=%b required 0", tag, bus.busy);
    else passes++;
  endtask

  task automatic test_reset;
    bus.req = '0;
    bus.tx_valid = '0;
    bus.tx_data = '0;
    rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if ({bus.gnt, bus.tx_ready, bus.rx_valid} !== 6'b0) $display("FAIL reset_handshake: gnt/ready/rxv=%b required 0", {bus.gnt, bus.tx_ready, bus.rx_valid});
    else passes++;
    checks++;
    if (bus.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h required 00", bus.rx_data);
    else passes++;
    checks++;
    if ({bus.busy, spi_sck, spi_mosi} !== 3'b000) $display("FAIL reset_pins: busy/sck/mosi=%b required 000", {bus.busy, spi_sck, spi_mosi});
    else passes++;
    checks++;
    if (spi_cs_n !== 2'b11) $display("FAIL reset_cs: got %b required 11", spi_cs_n);
    else passes++;
    m_last = 1'b1;
    #2 rst_n = 1'b1;
    tick;
  endtask

  task automatic test_round_robin;
    logic [1:0] g, e;
    logic [7:0] b, got, cap;
    int lat, n, w;
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      e = exp_grant(2'b11);
      wait_gnt(g);
      checks++;
      if (g !== e) $display("FAIL rr_grant_%0d: gnt=%b required %b", i, g, e);
      else passes++;
      m_last = e[1];
      w = e[1] ? 1 : 0;
      b = 8'($urandom);
      send_byte(w, b, -1, got, lat);
      checks++;
      if (got !== b) $display("FAIL rr_loopback_%0d: rx=%h required %h", i, got, b);
      else passes++;
      get_mosi(cap);
      bus.req[w] = 1'b0;
      n = 0;
      while (bus.gnt != 2'b00 && n < 50) begin
        tick;
        n++;
      end
      if (i == 3) bus.req = 2'b00;
      else        bus.req[w] = 1'b1;
    end
    wait_idle;
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [7:0] got, cap;
    int n = 0, lat, r0, c0;
    bus.req = 2'b01;
    while (spi_cs_n == 2'b11 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (bus.gnt !== exp_grant(2'b01) || spi_cs_n !== 2'b10) $display("FAIL single_grant: gnt=%b cs=%b required 01/10", bus.gnt, spi_cs_n);
    else passes++;
    m_last = 1'b0;
    n = 0;
    while (!bus.tx_ready[0] && n < 50) begin
      tick;
      n++;
    end
    checks++;
    if (n !== CS_SETUP) $display("FAIL single_setup: cycles=%0d required %0d", n, CS_SETUP);
    else passes++;
    r0 = rise_cnt;
    c0 = cs_changes;
    send_byte(0, b, -1, got, lat);
    checks++;
    if (lat !== BYTE_LAT) $display("FAIL single_latency: cycles=%0d required %0d", lat, BYTE_LAT);
    else passes++;
    checks++;
    if (got !== b) $display("FAIL single_rx: got %h required %h", got, b);
    else passes++;
    checks++;
    if (rise_cnt - r0 !== 8) $display("FAIL single_sck_rises: got %0d required 8", rise_cnt - r0);
    else passes++;
    get_mosi(cap);
    checks++;
    if (cap !== b) $display("FAIL single_mosi: got %h required %h", cap, b);
    else passes++;
    checks++;
    if (cs_changes !== c0 || spi_cs_n !== 2'b10) $display("FAIL single_cs_stable: changes=%0d cs=%b required 0/10", cs_changes - c0, spi_cs_n);
    else passes++;
    check_release("single");
  endtask

  task automatic test_back_to_back;
    logic [1:0] g;
    logic [7:0] cap;
    int n = 0;
    bus.req = 2'b10;
    wait_gnt(g);
    checks++;
    if (g !== exp_grant(2'b10)) $display("FAIL b2b_grant: gnt=%b required 10", g);
    else passes++;
    m_last = 1'b1;
    bus.tx_data[15:8] = 8'h3C;
    bus.tx_valid[1] = 1'b1;
    while (!bus.tx_ready[1] && n < 50) begin
      tick;
      n++;
    end
    tick;
    bus.tx_data[15:8] = 8'hC3;
    n = 0;
    while (!bus.rx_valid[1] && n < 400) begin
      tick;
      n++;
    end
    checks++;
    if (bus.rx_data !== 8'h3C || n !== BYTE_LAT) $display("FAIL b2b_first: rx=%h lat=%0d required 3c/%0d", bus.rx_data, n, BYTE_LAT);
    else passes++;
    checks++;
    if (bus.tx_ready[1] !== 1'b1) $display("FAIL b2b_same_cycle_accept: tx_ready[1]=%b required 1", bus.tx_ready[1]);
    else passes++;
    tick;
    bus.tx_valid[1] = 1'b0;
    n = 0;
    while (!bus.rx_valid[1] && n < 400) begin
      tick;
      n++;
    end
    checks++;
    if (bus.rx_data !== 8'hC3 || n !== BYTE_LAT) $display("FAIL b2b_second: rx=%h lat=%0d required c3/%0d", bus.rx_data, n, BYTE_LAT);
    else passes++;
    get_mosi(cap);
    checks++;
    if (cap !== 8'h3C) $display("FAIL b2b_mosi0: got %h required 3c", cap);
    else passes++;
    get_mosi(cap);
    checks++;
    if (cap !== 8'hC3) $display("FAIL b2b_mosi1: got %h required c3", cap);
    else passes++;
    check_release("b2b");
  endtask

  task automatic test_mid_drop;
    logic [1:0] g;
    logic [7:0] b, got, cap;
    int lat;
    bus.req = 2'b01;
    wait_gnt(g);
    m_last = 1'b0;
    b = 8'($urandom);
    send_byte(0, b, 3, got, lat);
    checks++;
    if (bus.rx_valid[0] !== 1'b1 || lat !== BYTE_LAT || got !== b) $display("FAIL middrop_byte: rxv=%b lat=%0d rx=%h required 1/%0d/%h", bus.rx_valid[0], lat, got, BYTE_LAT, b);
    else passes++;
    get_mosi(cap);
    check_release("middrop");
  endtask

  task automatic test_ignore_other;
    logic [1:0] g;
    logic [7:0] b, got, cap;
    int lat, r0;
    bus.tx_data[15:8] = 8'hFF;
    bus.tx_valid[1] = 1'b1;
    bus.req = 2'b01;
    wait_gnt(g);
    checks++;
    if (g !== 2'b01 || bus.tx_ready[1] !== 1'b0) $display("FAIL other_grant: gnt=%b ready1=%b required 01/0", g, bus.tx_ready[1]);
    else passes++;
    m_last = 1'b0;
    b = 8'($urandom);
    send_byte(0, b, -1, got, lat);
    checks++;
    if (bus.tx_ready[1] !== 1'b0 || bus.rx_valid[1] !== 1'b0) $display("FAIL other_handshake: ready1=%b rxv1=%b required 0/0", bus.tx_ready[1], bus.rx_valid[1]);
    else passes++;
    get_mosi(cap);
    checks++;
    if (cap !== b) $display("FAIL other_mosi: got %h required %h", cap, b);
    else passes++;
    check_release("other");
    r0 = rise_cnt;
    repeat (20) tick;
    checks++;
    if (rise_cnt !== r0 || bus.busy !== 1'b0) $display("FAIL other_no_shift: rises=%0d busy=%b required 0/0", rise_cnt - r0, bus.busy);
    else passes++;
    bus.tx_valid[1] = 1'b0;
  endtask

  task automatic test_random;
    logic [1:0] pat, g, e;
    logic [7:0] b, got, cap;
    int lat, w, nb;
    miso_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pat = 2'($urandom_range(1, 3));
      e = exp_grant(pat);
      bus.req = pat;
      wait_gnt(g);
      checks++;
      if (g !== e) $display("FAIL rand_grant_%0d: gnt=%b required %b (req=%b)", i, g, e, pat);
      else passes++;
      m_last = e[1];
      w = e[1] ? 1 : 0;
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom);
        slave_byte = 8'($urandom);
        send_byte(w, b, -1, got, lat);
        checks++;
        if (got !== slave_byte) $display("FAIL rand_rx_%0d_%0d: got %h required %h", i, j, got, slave_byte);
        else passes++;
        get_mosi(cap);
        checks++;
        if (cap !== b) $display("FAIL rand_mosi_%0d_%0d: got %h required %h", i, j, cap, b);
        else passes++;
      end
      bus.req = 2'b00;
      wait_idle;
    end
    miso_mode = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    logic [1:0] g;
    logic [7:0] got, cap;
    int n = 0, lat;
    bus.req = 2'b10;
    wait_gnt(g);
    m_last = 1'b1;
    bus.tx_data[15:8] = 8'h5A;
    bus.tx_valid[1] = 1'b1;
    while (!bus.tx_ready[1] && n < 50) begin
      tick;
      n++;
    end
    tick;
    bus.tx_valid[1] = 1'b0;
    repeat (5) tick;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (spi_cs_n !== 2'b11 || spi_sck !== 1'b0) $display("FAIL rst_mid_pins: cs=%b sck=%b required 11/0", spi_cs_n, spi_sck);
    else passes++;
    checks++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) $display("FAIL rst_mid_state: gnt=%b busy=%b required 00/0", bus.gnt, bus.busy);
    else passes++;
    m_last = 1'b1;
    bus.req = 2'b00;
    tick;
    tick;
    #2 rst_n = 1'b1;
    tick;
    bus.req = 2'b10;
    wait_gnt(g);
    checks++;
    if (g !== exp_grant(2'b10)) $display("FAIL rst_regrant: gnt=%b required 10", g);
    else passes++;
    m_last = 1'b1;
    send_byte(1, 8'h96, -1, got, lat);
    checks++;
    if (got !== 8'h96 || lat !== BYTE_LAT) $display("FAIL rst_after_byte: rx=%h lat=%0d required 96/%0d", got, lat, BYTE_LAT);
    else passes++;
    get_mosi(cap);
    check_release("rst");
  endtask

  task automatic test_invariants;
    checks++;
    if (inv_bad !== 0) $display("FAIL cs_invariants: violations=%0d required 0", inv_bad);
    else passes++;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single(8'hA5);
    test_single(8'($urandom));
    test_back_to_back;
    test_mid_drop;
    test_ignore_other;
    test_random;
    test_reset_mid_shift;
    test_invariants;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
